// File: rtl/regfile_sb.sv
// regfile_sb: parametrised multi-read-port register file with an integrated RAW scoreboard.
// Optional write-to-read bypass is compiled in when REGFILE_SB_BYPASS_EN is defined.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_count
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [ADDR_W:0]   count_next;
  logic              wr_ok;
  logic              iss_ok;
  logic              inc;
  logic              dec;

  // Register 0 is never written nor marked, so its busy bit stays 0 forever.
  assign wr_ok  = wr_en  && (wr_addr  != '0);
  assign iss_ok = iss_en && (iss_addr != '0);

  // A same-address issue is newer than the write, so that write clears nothing.
  assign inc = iss_ok && !busy[iss_addr];
  assign dec = wr_ok && busy[wr_addr] && !(iss_ok && (iss_addr == wr_addr));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[wr_addr]  = 1'b0;
    if (iss_ok) busy_next[iss_addr] = 1'b1;
    if (flush)  busy_next = '0;
  end

  always_comb begin
    count_next = busy_count + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    if (flush) count_next = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  // NOTE: the data array is reset because reads must return 0 after reset; this
  // forces it into flops instead of a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      d = mem[ra];
      b = busy[ra];
      if (ra == '0) begin
        d = '0;
        b = 1'b0;
      end
`ifdef REGFILE_SB_BYPASS_EN
      else if (wr_ok && (wr_addr == ra)) begin
        d = wr_data;
        b = 1'b0;
      end
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k]                  = b;
  end

endmodule
